// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel debouncer with rise/fall pulses
// Optional 2-flop input synchronizer selected by DEBOUNCE_SYNC_EN.
module debounce_bank #(
    parameter int   N       = 4,
    parameter int   THRESH  = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         enable,
    input  logic [N-1:0] in,
    output logic [N-1:0] out,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         any_edge
);
    localparam int CW = $clog2(THRESH + 1);

    logic [N-1:0]  s_q, s_d;
    logic [N-1:0]  out_q, out_d;
    logic [N-1:0]  rise_q, rise_d;
    logic [N-1:0]  fall_q, fall_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

`ifdef DEBOUNCE_SYNC_EN
    logic [N-1:0] sync1_q, sync1_d;

    always_comb begin
        sync1_d = in;
        s_d     = sync1_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) sync1_q <= {N{RST_VAL}};
        else       sync1_q <= sync1_d;
    end
`else
    always_comb begin
        s_d = in;
    end
`endif

    // A channel flips only after THRESH consecutive enabled mismatches.
    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s_q[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (enable) begin
                if (cnt_q[i] == CW'(THRESH - 1)) begin
                    cnt_d[i]  = '0;
                    out_d[i]  = s_q[i];
                    rise_d[i] = s_q[i];
                    fall_d[i] = ~s_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s_q    <= {N{RST_VAL}};
            out_q  <= {N{RST_VAL}};
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            s_q    <= s_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign out      = out_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign any_edge = |(rise_q | fall_q);

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - randomized and directed bench for debounce_bank
module tb_debounce_bank;
    localparam int N      = 4;
    localparam int THRESH = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam int LAT = L - 1 + THRESH;

    logic         CLK = 1'b0;
    logic         reset_r;
    logic         enable_r;
    logic [N-1:0] in_r;
    logic [N-1:0] out, rise, fall;
    logic         any_edge;

    debounce_bank #(.N(N), .THRESH(THRESH), .RST_VAL(1'b0)) dut (
        .CLK(CLK), .RESET(reset_r), .enable(enable_r), .in(in_r),
        .out(out), .rise(rise), .fall(fall), .any_edge(any_edge)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] pipe_m [L];
    logic [N-1:0] out_m, rise_m, fall_m;
    int           run_m [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the input is seen L edges late; each channel counts its
    // current run of enabled disagreeing samples and flips when it hits THRESH.
    task automatic model_edge(input logic [N-1:0] iv, input logic en, input logic rst);
        logic [N-1:0] s;
        s      = pipe_m[L-1];
        rise_m = '0;
        fall_m = '0;
        if (rst) begin
            for (int k = 0; k < L; k++) pipe_m[k] = '0;
            out_m = '0;
            for (int i = 0; i < N; i++) run_m[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (s[i] == out_m[i]) run_m[i] = 0;
                else if (en) begin
                    run_m[i] = run_m[i] + 1;
                    if (run_m[i] >= THRESH) begin
                        out_m[i] = s[i];
                        run_m[i] = 0;
                        if (s[i]) rise_m[i] = 1'b1;
                        else      fall_m[i] = 1'b1;
                    end
                end
            end
            for (int k = L - 1; k > 0; k--) pipe_m[k] = pipe_m[k-1];
            pipe_m[0] = iv;
        end
    endtask

    task automatic step(input logic [N-1:0] iv, input logic en, input logic rst);
        in_r     = iv;
        enable_r = en;
        reset_r  = rst;
        @(posedge CLK);
        model_edge(iv, en, rst);
        #1;
        check("out", 32'(out), 32'(out_m));
        check("rise", 32'(rise), 32'(rise_m));
        check("fall", 32'(fall), 32'(fall_m));
        check("any_edge", 32'(any_edge), 32'(|(rise_m | fall_m)));
    endtask

    initial begin
        int hit_edge, seen, bad, rise_cnt, chg_k;
        logic prev;
        logic [N-1:0] cur;
        in_r = '0; enable_r = 1'b1; reset_r = 1'b1;
        for (int k = 0; k < L; k++) pipe_m[k] = '0;
        out_m = '0; rise_m = '0; fall_m = '0;
        for (int i = 0; i < N; i++) run_m[i] = 0;
        @(negedge CLK);

        // reset with all inputs high
        for (int k = 0; k < 3; k++) begin
            step(4'hF, 1'b1, 1'b1);
            check("reset_out", 32'(out), 32'h0);
        end
        for (int k = 0; k < 8; k++) step(4'h0, 1'b1, 1'b0);

        // bounce rejection on channel 0
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step({3'b000, ~k[1]}, 1'b1, 1'b0);
            if (out[0]) seen++;
        end
        check("bounce_quiet", 32'(seen), 32'h0);
        hit_edge = -1; rise_cnt = 0;
        for (int e = 0; e < 12; e++) begin
            step(4'h1, 1'b1, 1'b0);
            if (out[0] && hit_edge < 0) hit_edge = e;
            if (rise[0]) rise_cnt++;
        end
        check("bounce_edge", 32'(hit_edge), 32'(LAT));
        check("bounce_rise_cnt", 32'(rise_cnt), 32'h1);

        // short glitch on channel 1
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            step(4'h3, 1'b1, 1'b0);
            if (out[1] || rise[1] || any_edge) seen++;
        end
        for (int k = 0; k < 10; k++) begin
            step(4'h1, 1'b1, 1'b0);
            if (out[1] || rise[1] || any_edge) seen++;
        end
        check("glitch", 32'(seen), 32'h0);

        // enable pulsed one cycle in three
        bad = 0; chg_k = -1;
        for (int k = 0; k < 30; k++) begin
            prev = out[2];
            step(4'h5, (k % 3) == 0, 1'b0);
            if ((k % 3) != 0 && out[2] != prev) bad++;
            if (out[2] && chg_k < 0) chg_k = k;
        end
        check("gate_no_change_when_off", 32'(bad), 32'h0);
        check("gate_change_edge", 32'(chg_k), 32'd12);

        // simultaneous falls on channels 3:2
        for (int k = 0; k < 10; k++) step(4'hF, 1'b1, 1'b0);
        check("all_high", 32'(out), 32'hF);
        for (int e = 0; e <= LAT; e++) step(4'h3, 1'b1, 1'b0);
        check("fall_pair", 32'(fall), 32'hC);
        check("fall_any", 32'(any_edge), 32'h1);
        check("fall_low_unchanged", 32'(out[1:0]), 32'h3);
        step(4'h3, 1'b1, 1'b0);
        check("fall_one_cycle", 32'(fall), 32'h0);

        // reset lands one edge before channel 0 would rise
        for (int k = 0; k < 10; k++) step(4'h0, 1'b1, 1'b0);
        for (int e = 0; e < LAT - 1; e++) step(4'h1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(4'h1, 1'b1, 1'b1);
            check("rst_mid_rise", 32'(rise[0]), 32'h0);
            check("rst_mid_out", 32'(out[0]), 32'h0);
        end

        // random traffic: mostly stable bits, random enable, rare reset
        cur = 4'h1;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) cur[i] = ~cur[i];
            step(cur, $urandom_range(3) != 0, $urandom_range(99) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
